// File: rtl/unsigned_adder_tree_pipelined.sv
// unsigned_adder_tree_pipelined
//
// Pipelined binary adder tree. It reduces LENGTH unsigned DATA_WIDTH-bit
// addends to one full-precision sum. Each tree level has one register
// stage. A single enable advances or freezes every stage together, so the
// whole tree stalls as one unit.
//
// Parameters
//   DATA_WIDTH : width of each unsigned addend
//   LENGTH     : number of addends (must be >= 2)
//   LEVELS     : derived, ceil(log2(LENGTH)); tree depth and latency
//   SUM_WIDTH  : derived, DATA_WIDTH + LEVELS; output width
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : asynchronous active-high reset; clears levels 2 and up
//   in_addends : unpacked array of LENGTH addends, index 0..LENGTH-1
//   in_advance : global pipeline enable; 0 freezes every level
//   out_sum    : registered sum of the set that entered LEVELS advancing
//                edges earlier
//
// There is no valid flag. The consumer tracks latency itself, and any stale
// or unknown input simply flows through as data.

module unsigned_adder_tree_pipelined #(
  parameter  int DATA_WIDTH = 8,
  parameter  int LENGTH     = 5,
  localparam int LEVELS     = $clog2(LENGTH),
  localparam int SUM_WIDTH  = DATA_WIDTH + LEVELS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_addends [LENGTH],
  input  logic                  in_advance,
  output logic [SUM_WIDTH-1:0]  out_sum
);

  // Number of elements present after 'lvl' halving steps. Level 0 is the
  // raw addend vector. Each level pairs neighbours, and an odd element
  // out passes straight through, so the count is ceil(previous / 2).
  function automatic int count_at(input int lvl);
    int c;
    c = LENGTH;
    for (int i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // One generate iteration per tree level. Level k reads the level k-1
  // registers, or the raw inputs when k is 1. It adds adjacent pairs one
  // bit wider than its inputs, so a carry can never be lost.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int IN_W    = DATA_WIDTH + k - 1;
    localparam int OUT_W   = DATA_WIDTH + k;
    localparam int IN_CNT  = count_at(k - 1);
    localparam int OUT_CNT = count_at(k);

    logic [IN_W-1:0]  src   [IN_CNT];
    logic [OUT_W-1:0] sum_d [OUT_CNT];
    logic [OUT_W-1:0] sum_q [OUT_CNT];

    // Source selection. Level 1 sees the raw addends, and every deeper
    // level sees the registered outputs of the level above it.
    if (k == 1) begin : g_src_in
      for (genvar i = 0; i < IN_CNT; i++) begin : g_elem
        assign src[i] = in_addends[i];
      end
    end else begin : g_src_prev
      for (genvar i = 0; i < IN_CNT; i++) begin : g_elem
        assign src[i] = g_level[k-1].sum_q[i];
      end
    end

    // Pairwise reduction. Element j sums inputs 2j and 2j+1. When the input
    // count is odd, the last output has no partner and carries its single
    // input zero-extended by one bit.
    for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
      if (2 * j + 1 < IN_CNT) begin : g_add
        assign sum_d[j] = OUT_W'(src[2*j]) + OUT_W'(src[2*j+1]);
      end else begin : g_pass
        assign sum_d[j] = {1'b0, src[2*j]};
      end
    end

    // Level register. Level 1 has no reset. That lets an operand set
    // presented alongside reset still be captured, and it lets the set
    // sitting in level 1 survive a reset and move on afterwards. Deeper
    // levels clear asynchronously, which discards whatever is in flight
    // there. All levels share in_advance, so a stall freezes the whole
    // tree without losing or duplicating data.
    if (k == 1) begin : g_reg_noreset
      always_ff @(posedge clk) begin
        if (in_advance) begin
          sum_q <= sum_d;
        end
      end
    end else begin : g_reg_reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int j = 0; j < OUT_CNT; j++) begin
            sum_q[j] <= '0;
          end
        end else if (in_advance) begin
          sum_q <= sum_d;
        end
      end
    end
  end

  // The last level always holds exactly one element, and its width is
  // DATA_WIDTH + LEVELS, which equals SUM_WIDTH. It drives the output
  // directly with no further extension.
  assign out_sum = g_level[LEVELS].sum_q[0];

endmodule

// File: tb/tb_unsigned_adder_tree_pipelined.sv
// tb_unsigned_adder_tree_pipelined
//
// Self-checking bench for unsigned_adder_tree_pipelined. It uses three
// instances:
//   dut_d  : defaults (DATA_WIDTH=8, LENGTH=5, LEVELS=3, SUM_WIDTH=11)
//   dut_w  : DATA_WIDTH=4, LENGTH=8 (LEVELS=3, SUM_WIDTH=7)
//   dut_l  : DATA_WIDTH=8, LENGTH=2 (LEVELS=1, SUM_WIDTH=9)
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// at that same offset.

module tb_unsigned_adder_tree_pipelined;

  typedef struct {
    logic [4:0][7:0] a;
    logic [10:0]     sum;
  } vec_t;

  localparam int NVEC = 7;

  logic        clk;
  logic        reset;

  logic [7:0]  d_addends [5];
  logic        d_advance;
  logic [10:0] d_sum;

  logic [3:0]  w_addends [8];
  logic        w_advance;
  logic [6:0]  w_sum;

  logic [7:0]  l_addends [2];
  logic        l_advance;
  logic [8:0]  l_sum;

  int checks;
  int errors;

  vec_t vecs [NVEC];

  unsigned_adder_tree_pipelined dut_d (
    .clk        (clk),
    .reset      (reset),
    .in_addends (d_addends),
    .in_advance (d_advance),
    .out_sum    (d_sum)
  );

  unsigned_adder_tree_pipelined #(.DATA_WIDTH(4), .LENGTH(8)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .in_addends (w_addends),
    .in_advance (w_advance),
    .out_sum    (w_sum)
  );

  unsigned_adder_tree_pipelined #(.DATA_WIDTH(8), .LENGTH(2)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .in_addends (l_addends),
    .in_advance (l_advance),
    .out_sum    (l_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0][7:0] a, input logic adv);
    for (int i = 0; i < 5; i++) begin
      d_addends[i] = a[i];
    end
    d_advance = adv;
  endtask

  task automatic applyIdle(input logic adv);
    for (int i = 0; i < 5; i++) begin
      d_addends[i] = 'x;
    end
    d_advance = adv;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Streams the vector table through dut_d with an optional stall window.
  // A small latency scoreboard tracks which expected sum sits in each of
  // the three in-flight slots. A stall leaves the slots untouched, so the
  // output must stay frozen.
  task automatic runStream(input int tag, input int stall_start, input int stall_len);
    logic [10:0] pipe [3];
    bit          pv   [3];
    int          nxt;
    bit          adv;
    bit          pushing;
    nxt = 0;
    for (int s = 0; s < 3; s++) begin
      pipe[s] = '0;
      pv[s]   = 1'b0;
    end
    for (int c = 0; c < NVEC + 2 + stall_len; c++) begin
      adv     = !(c >= stall_start && c < stall_start + stall_len);
      pushing = adv && (nxt < NVEC);
      if (pushing) applyStimulus(vecs[nxt].a, 1'b1);
      else         applyIdle(adv);
      tick();
      if (adv) begin
        pipe[2] = pipe[1]; pv[2] = pv[1];
        pipe[1] = pipe[0]; pv[1] = pv[0];
        if (pushing) begin
          pipe[0] = vecs[nxt].sum;
          pv[0]   = 1'b1;
          nxt++;
        end else begin
          pv[0] = 1'b0;
        end
      end
      if (pv[2]) begin
        checkOutput($sformatf("stream%0d_c%0d", tag, c), 32'(d_sum), 32'(pipe[2]));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{a: {8'd1,   8'd1,   8'd1,   8'd1,   8'd1},   sum: 11'd5};
    vecs[1] = '{a: {8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, sum: 11'd1275};
    vecs[2] = '{a: {8'd7,   8'd0,   8'd0,   8'd0,   8'd0},   sum: 11'd7};
    vecs[3] = '{a: {8'd50,  8'd40,  8'd30,  8'd20,  8'd10},  sum: 11'd150};
    vecs[4] = '{a: {8'd255, 8'd0,   8'd255, 8'd0,   8'd255}, sum: 11'd765};
    vecs[5] = '{a: {8'd8,   8'd16,  8'd32,  8'd64,  8'd128}, sum: 11'd248};
    vecs[6] = '{a: {8'd0,   8'd0,   8'd0,   8'd0,   8'd0},   sum: 11'd0};

    reset     = 1'b0;
    w_advance = 1'b0;
    l_advance = 1'b0;
    for (int i = 0; i < 8; i++) w_addends[i] = '0;
    for (int i = 0; i < 2; i++) l_addends[i] = '0;
    applyIdle(1'b0);

    // Reset with capture: the set {2,3,5,8,13} is captured on the edge
    // where reset is high. One stall follows, so 31 appears after the
    // fourth edge.
    #2;
    reset = 1'b1;
    applyStimulus({8'd13, 8'd8, 8'd5, 8'd3, 8'd2}, 1'b1);
    #1;
    checkOutput("reset_asserted", 32'(d_sum), 32'd0);
    tick();
    reset = 1'b0;
    applyIdle(1'b1);
    checkOutput("capture_e0", 32'(d_sum), 32'd0);
    tick();
    checkOutput("capture_e1", 32'(d_sum), 32'd0);
    applyIdle(1'b0);
    tick();
    checkOutput("capture_e2_stall", 32'(d_sum), 32'd0);
    applyIdle(1'b1);
    tick();
    checkOutput("capture_e3", 32'(d_sum), 32'd31);
    applyIdle(1'b0);
    tick();
    checkOutput("capture_hold1", 32'(d_sum), 32'd31);
    tick();
    checkOutput("capture_hold2", 32'(d_sum), 32'd31);

    // Reset while stalled clears the output without any clock edge.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_clear_stalled", 32'(d_sum), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus({8'd13, 8'd8, 8'd5, 8'd3, 8'd2}, 1'b1);
    tick();
    applyIdle(1'b1);
    tick();
    tick();
    checkOutput("after_stalled_reset", 32'(d_sum), 32'd31);

    // Back-to-back streaming, first with no stall and then with a 5-cycle
    // stall in the middle of the stream.
    runStream(0, 1000, 0);
    runStream(1, 4, 5);

    // Asynchronous reset mid-flight: S1 (sum 15) is in level 2 and S2
    // (sum 50) is in level 1. The reset pulse falls between edges, so only
    // S2 emerges afterwards.
    applyStimulus({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    tick();
    applyStimulus({8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 1'b1);
    tick();
    applyIdle(1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midflight_async_clear", 32'(d_sum), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("midflight_e1", 32'(d_sum), 32'd0);
    tick();
    checkOutput("midflight_e2_level1_set", 32'(d_sum), 32'd50);
    applyIdle(1'b0);

    // Wider tree: LENGTH=8, DATA_WIDTH=4.
    for (int i = 0; i < 8; i++) w_addends[i] = 4'd15;
    w_advance = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) w_addends[i] = 4'(i + 1);
    tick();
    for (int i = 0; i < 8; i++) w_addends[i] = '0;
    tick();
    checkOutput("len8_all15", 32'(w_sum), 32'd120);
    tick();
    checkOutput("len8_one_to_eight", 32'(w_sum), 32'd36);
    w_advance = 1'b0;

    // Minimal tree: LENGTH=2, a single level with one-edge latency.
    l_addends[0] = 8'd200;
    l_addends[1] = 8'd100;
    l_advance    = 1'b1;
    tick();
    checkOutput("len2_first", 32'(l_sum), 32'd300);
    l_addends[0] = 8'd255;
    l_addends[1] = 8'd255;
    tick();
    checkOutput("len2_max", 32'(l_sum), 32'd510);
    l_advance    = 1'b0;
    l_addends[0] = 8'd1;
    l_addends[1] = 8'd1;
    tick();
    checkOutput("len2_hold", 32'(l_sum), 32'd510);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
